// File: rtl/seg_scan_reader.sv
// Seven-segment scan capture: settles each selected digit, decodes it
// back to a nibble and emits a full frame once every digit is seen.
module seg_scan_reader #(
  parameter int NUM_DIGITS = 4,
  parameter int SETTLE     = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    valid,
  output logic [NUM_DIGITS-1:0]   err_mask,
  output logic                    frame_err
);

  localparam int N  = NUM_DIGITS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE,
    SETTLING,
    HELD
  } state_t;

  state_t         state_q, state_d;
  logic [6:0]     s_seg_q, s_seg_d;
  logic [N-1:0]   s_an_q, s_an_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [N-1:0]   mask_q, mask_d;
  logic [4*N-1:0] stg_q, stg_d;
  logic [N-1:0]   serr_q, serr_d;
  logic [4*N-1:0] value_q, value_d;
  logic           valid_q, valid_d;
  logic [N-1:0]   err_mask_q, err_mask_d;
  logic           frame_err_q, frame_err_d;

  logic          chg;
  logic          sel_ok;
  logic          nxt_ok;
  logic [IW-1:0] idx;
  logic [3:0]    nib;
  logic          bad;
  logic          cap;

  assign chg    = {seg_n, an_n} != {s_seg_q, s_an_q};
  assign sel_ok = $countones(~s_an_q) == 1;
  assign nxt_ok = $countones(~an_n) == 1;
  assign s_seg_d = seg_n;
  assign s_an_d  = an_n;

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!s_an_q[i]) idx = IW'(i);
    end
  end

  always_comb begin
    nib = 4'h0;
    bad = 1'b0;
    case (s_seg_q)
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001111: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0000100: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b1100000: nib = 4'hB;
      7'b0110001: nib = 4'hC;
      7'b1000010: nib = 4'hD;
      7'b0110000: nib = 4'hE;
      7'b0111000: nib = 4'hF;
      default:    bad = 1'b1;
    endcase
  end

  // Capture only if this edge does not also end the dwell, so a dwell
  // must last SETTLE+1 cycles to be taken.
  assign cap = (state_q == SETTLING) && sel_ok && !chg &&
               (cnt_q == SETTLE_C);

  always_comb begin
    state_d = state_q;
    if (chg) begin
      state_d = nxt_ok ? SETTLING : IDLE;
    end else if (!sel_ok) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:     state_d = SETTLING;
        SETTLING: if (cap) state_d = HELD;
        HELD:     state_d = HELD;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    stg_d       = stg_q;
    serr_d      = serr_q;
    value_d     = value_q;
    err_mask_d  = err_mask_q;
    frame_err_d = frame_err_q;
    valid_d     = 1'b0;
    if (chg) cnt_d = 4'd1;
    else if (cnt_q < SETTLE_C) cnt_d = cnt_q + 4'd1;
    if (cap) begin
      stg_d[{idx, 2'b00} +: 4] = nib;
      serr_d[idx] = bad;
      mask_d[idx] = 1'b1;
      if (&mask_d) begin
        value_d     = stg_d;
        err_mask_d  = serr_d;
        frame_err_d = |serr_d;
        valid_d     = 1'b1;
        mask_d      = '0;
        serr_d      = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_seg_q     <= 7'h7F;
      s_an_q      <= '1;
      cnt_q       <= 4'd0;
      mask_q      <= '0;
      stg_q       <= '0;
      serr_q      <= '0;
      value_q     <= '0;
      valid_q     <= 1'b0;
      err_mask_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_seg_q     <= s_seg_d;
      s_an_q      <= s_an_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      stg_q       <= stg_d;
      serr_q      <= serr_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      err_mask_q  <= err_mask_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign value     = value_q;
  assign valid     = valid_q;
  assign err_mask  = err_mask_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Bench for seg_scan_reader: directed scenarios plus random scans,
// checked every cycle against a dwell-level reference model.
module tb_seg_scan_reader;

  localparam int N = 4;
  localparam int S = 3;

  localparam logic [6:0] PAT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [6:0]   seg_n = 7'h7F;
  logic [N-1:0] an_n = '1;
  logic [15:0]  value;
  logic         valid;
  logic [N-1:0] err_mask;
  logic         frame_err;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;

  logic [3:0]  m_nib [N];
  logic        m_bad [N];
  logic [3:0]  m_mask;
  logic [15:0] m_value;
  logic [3:0]  m_em;
  logic        m_fe;
  logic        m_valid;
  logic [10:0] m_prev;
  int          m_run;

  always #5 clk = ~clk;

  seg_scan_reader #(.NUM_DIGITS(N), .SETTLE(S)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_n(seg_n),
    .an_n(an_n),
    .value(value),
    .valid(valid),
    .err_mask(err_mask),
    .frame_err(frame_err)
  );

  function automatic int sel_idx(input logic [3:0] a);
    int z = 0;
    int k = -1;
    for (int i = 0; i < N; i++) begin
      if (!a[i]) begin
        z++;
        k = i;
      end
    end
    return (z == 1) ? k : -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_nib[i] = 4'h0;
      m_bad[i] = 1'b0;
    end
    m_mask  = '0;
    m_value = '0;
    m_em    = '0;
    m_fe    = 1'b0;
    m_valid = 1'b0;
    m_prev  = {7'h7F, 4'hF};
    m_run   = 0;
  endtask

  // A legal dwell is taken on its (S+1)th consecutive cycle.
  task automatic model_edge(input logic [6:0] s, input logic [3:0] a);
    int k;
    logic [3:0] n;
    logic b;
    m_valid = 1'b0;
    if ({s, a} != m_prev) m_run = 1;
    else m_run++;
    m_prev = {s, a};
    k = sel_idx(a);
    if (k >= 0 && m_run == S + 1) begin
      n = 4'h0;
      b = 1'b1;
      for (int p = 0; p < 16; p++) begin
        if (PAT[p] == s) begin
          n = 4'(p);
          b = 1'b0;
        end
      end
      m_nib[k] = n;
      m_bad[k] = b;
      m_mask[k] = 1'b1;
      if (m_mask == 4'hF) begin
        for (int i = 0; i < N; i++) begin
          m_value[4*i +: 4] = m_nib[i];
          m_em[i] = m_bad[i];
          m_bad[i] = 1'b0;
        end
        m_fe = |m_em;
        m_valid = 1'b1;
        m_mask = '0;
      end
    end
  endtask

  task automatic cycle(input logic [6:0] s, input logic [3:0] a);
    seg_n = s;
    an_n  = a;
    @(posedge clk);
    model_edge(s, a);
    #1;
    if (valid) valid_cnt++;
    checks++;
    if (valid !== m_valid) begin
      errors++;
      $display("FAIL cyc_valid t=%0t got %b exp %b", $time, valid, m_valid);
    end
    checks++;
    if (value !== m_value) begin
      errors++;
      $display("FAIL cyc_value t=%0t got %h exp %h", $time, value, m_value);
    end
    checks++;
    if (err_mask !== m_em) begin
      errors++;
      $display("FAIL cyc_errm t=%0t got %b exp %b", $time, err_mask, m_em);
    end
    checks++;
    if (frame_err !== m_fe) begin
      errors++;
      $display("FAIL cyc_ferr t=%0t got %b exp %b", $time, frame_err, m_fe);
    end
  endtask

  task automatic dwell(input logic [6:0] s, input logic [3:0] a, input int len);
    repeat (len) cycle(s, a);
  endtask

  task automatic show(input int d, input int v, input int len);
    logic [3:0] a;
    a = ~(4'b0001 << d);
    dwell(PAT[v], a, len);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    seg_n = 7'h7F;
    an_n  = '1;
    @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;
    checks++;
    if ({value, valid, err_mask, frame_err} !== '0) begin
      errors++;
      $display("FAIL reset_out got v=%h vl=%b em=%b fe=%b exp all 0",
               value, valid, err_mask, frame_err);
    end
  endtask

  task automatic expect_frame(input string nm, input logic [15:0] v,
                              input logic [3:0] em, input logic fe,
                              input int cnt);
    checks++;
    if (value !== v || err_mask !== em || frame_err !== fe) begin
      errors++;
      $display("FAIL %s got %h/%b/%b exp %h/%b/%b", nm,
               value, err_mask, frame_err, v, em, fe);
    end
    checks++;
    if (valid_cnt !== cnt) begin
      errors++;
      $display("FAIL %s_pulses got %0d exp %0d", nm, valid_cnt, cnt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
  endtask

  task automatic test_basic();
    valid_cnt = 0;
    show(0, 4, 6);
    show(1, 3, 6);
    show(2, 2, 6);
    show(3, 1, 6);
    expect_frame("basic", 16'h1234, 4'b0000, 1'b0, 1);
  endtask

  task automatic test_short_dwell();
    valid_cnt = 0;
    show(0, 15, 6);
    dwell(7'b0100000, 4'b1101, 2);
    show(1, 2, 6);
    show(2, 14, 6);
    show(3, 13, 6);
    expect_frame("short_dwell", 16'hDE2F, 4'b0000, 1'b0, 1);
  endtask

  task automatic test_blank();
    valid_cnt = 0;
    show(0, 5, 6);
    show(1, 6, 6);
    dwell(7'h7F, 4'b1011, 6);
    show(3, 7, 6);
    expect_frame("blank", 16'h7065, 4'b0100, 1'b1, 1);
    show(0, 1, 6);
    show(1, 2, 6);
    show(2, 3, 6);
    show(3, 4, 6);
    expect_frame("blank_clear", 16'h4321, 4'b0000, 1'b0, 2);
  endtask

  task automatic test_bad_select();
    valid_cnt = 0;
    show(0, 8, 6);
    show(1, 9, 6);
    dwell(PAT[3], 4'b0000, 10);
    dwell(PAT[3], 4'b1111, 10);
    expect_frame("bad_sel_hold", 16'h4321, 4'b0000, 1'b0, 0);
    show(2, 10, 6);
    show(3, 11, 6);
    expect_frame("bad_sel", 16'hBA98, 4'b0000, 1'b0, 1);
  endtask

  task automatic test_reset_mid();
    valid_cnt = 0;
    show(0, 1, 6);
    show(1, 2, 6);
    do_reset();
    show(0, 9, 6);
    show(1, 8, 6);
    show(2, 7, 6);
    show(3, 6, 6);
    expect_frame("reset_mid", 16'h6789, 4'b0000, 1'b0, 1);
  endtask

  task automatic test_back_to_back();
    valid_cnt = 0;
    for (int d = 0; d < N; d++) show(d, 10 + d, 6);
    expect_frame("b2b_1", 16'hDCBA, 4'b0000, 1'b0, 1);
    for (int d = 0; d < N; d++) show(d, 0, 6);
    expect_frame("b2b_2", 16'h0000, 4'b0000, 1'b0, 2);
  endtask

  task automatic test_random();
    logic [6:0] s;
    logic [3:0] a;
    int len;
    for (int t = 0; t < 400; t++) begin
      len = $urandom_range(1, 7);
      if ($urandom_range(0, 3) != 0) a = ~(4'b0001 << $urandom_range(0, 3));
      else a = 4'($urandom);
      if ($urandom_range(0, 4) != 0) s = PAT[$urandom_range(0, 15)];
      else s = 7'($urandom);
      dwell(s, a, len);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_short_dwell();
    test_blank();
    test_bad_select();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_reader.md
# seg_scan_reader

Capture block for multiplexed seven-segment display buses. Samples the active-low segment lines and active-low digit-select (anode) lines driven by the display path, waits for each selected digit to settle, and inverts the team's hex-to-segment encoding back to 4-bit nibbles. When every digit has been captured at least once, it presents a full-frame word with a one-cycle valid strobe. Used for on-board loopback checking and for bench self-checking of the display path.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits; legal 1..8.
- SETTLE, 3: consecutive identical samples required before a digit is captured; legal 1..15.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- seg_n  in  7  segments {A,B,C,D,E,F,G}; A is bit 6, G is bit 0; 0 means lit.
- an_n  in  NUM_DIGITS  digit select; an_n[i]=0 selects digit i.
- value  out  4*NUM_DIGITS  last completed frame; digit i in value[4i+3:4i].
- valid  out  1  one-cycle pulse when value updates.
- err_mask  out  NUM_DIGITS  bit i set if digit i's pattern in the last frame was not legal; updates with value.
- frame_err  out  1  OR of err_mask; updates with value.

## Operation
- Decided: one clock, clk; reset is synchronous, active-low, rst_n.
- Input stage: seg_n and an_n registered every cycle into s_seg and s_an. All decisions use the registered copies.
- Stability counter cnt, width 4, saturating at SETTLE:
  - Set to 1 when {s_seg, s_an} differs from the previous cycle's value.
  - Incremented otherwise.
- Selection: legal only when s_an has exactly one 0 bit; idx is that bit's position.
- FSM states: IDLE, SETTLING, HELD.
  - IDLE: selection is illegal. Go to SETTLING when the selection becomes legal.
  - SETTLING: when cnt==SETTLE, capture digit idx and go to HELD.
  - HELD: no further capture until {s_seg, s_an} changes. On a change, go to SETTLING if the selection is still legal, else IDLE.
  - From any state: an illegal selection goes to IDLE. cnt still tracks changes. The capture mask is preserved.
- Decode of s_seg (patterns written A..G):
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0001000, b:1100000
  - C:0110001, d:1000010, E:0110000, F:0111000
  - Any other pattern, including blank 1111111, is illegal: it writes nibble 0 and sets the staging error bit.
- Capture:
  - Writes the decoded nibble to staging slot idx, writes the staging error bit idx, and sets mask[idx].
  - Recapturing a digit before the frame completes overwrites that slot.
- Frame completion:
  - Occurs when a capture makes mask all ones.
  - On the same edge: value <= staging (including the new nibble), err_mask <= staging error bits (including the new one), frame_err <= OR of those bits, valid <= 1.
  - mask and staging error bits clear on that edge. Staging nibbles are not cleared.
- valid is deasserted on every edge that is not a completion.

## Timing
- Reset, when rst_n=0 at an edge:
  - value=0, valid=0, err_mask=0, frame_err=0.
  - mask=0, staging=0, cnt=0, state IDLE, s_seg=7'h7F, s_an all ones.
  - Reset overrides everything. Reset mid-frame discards the partial frame.
- Capture latency:
  - Inputs become stable before edge k.
  - Edge k: registers load, cnt=1.
  - Edge k+SETTLE-1: cnt reaches SETTLE.
  - Edge k+SETTLE: capture occurs.
  - If that capture completes the frame, valid is high for exactly the cycle after edge k+SETTLE.
- A dwell shorter than SETTLE+1 cycles produces no capture.
- Each dwell captures at most once, however long it lasts.
- An anode change and a segment change on the same cycle count as one change.
- With NUM_DIGITS=1, every capture completes a frame.

## Test plan
- Reset, then hold each digit 6 cycles showing 4, 3, 2, 1 on an_n[0..3] (SETTLE=3) -> one valid pulse after the digit-3 capture edge; value=16'h1234, err_mask=0, frame_err=0.
- Digit 1 shows 0100000 for 2 cycles, then 0010010 for 6 cycles -> slot 1 = 4'h2 and only one capture for digit 1; with other digits F, E, d -> value=16'hDE2F.
- Digit 2 shows 1111111 for 6 cycles in an otherwise legal frame -> value[11:8]=0, err_mask=4'b0100, frame_err=1; the next clean frame clears both.
- an_n=4'b0000 and an_n=4'b1111 held for 10 cycles each mid-frame -> no capture and no valid; the mask is preserved and the frame completes once the remaining digits are shown.
- Capture digits 0 and 1, assert rst_n=0 for one cycle, then show a full frame 9, 8, 7, 6 -> outputs all zero after reset; exactly one valid with value=16'h6789.
- Continuous scan: two back-to-back full frames A, b, C, d then 0, 0, 0, 0 -> two valid pulses, value=16'hDCBA then 16'h0000.
